// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG arbiter slice.
//   - trng_state_e : controller states
//   - TRNG_RDATA_W : width of the response data bus
//   - TRNG_IDX_W   : width of a requester index (up to 8 requesters)
//   - rr_next()    : round-robin successor of a requester index
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2,
    GAP     = 2'd3
  } trng_state_e;

  localparam int TRNG_RDATA_W = 32;
  localparam int TRNG_IDX_W   = 3;

  // Index following idx in an nreq-entry ring.
  function automatic logic [TRNG_IDX_W-1:0] rr_next(input logic [TRNG_IDX_W-1:0] idx,
                                                    input int nreq);
    int n;
    n = int'(idx) + 1;
    if (n >= nreq) n = 0;
    return TRNG_IDX_W'(n);
  endfunction

endpackage

// File: rtl/trng_rr_arb.sv
// Combinational NREQ-way round-robin picker.
//   req_i     : request vector
//   ptr_i     : highest-priority index for this pick
//   gnt_idx_o : first requester with req high, searching upward from ptr_i
//   gnt_vld_o : high when any request is present
module trng_rr_arb
  import trng_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]       req_i,
  input  logic [TRNG_IDX_W-1:0] ptr_i,
  output logic [TRNG_IDX_W-1:0] gnt_idx_o,
  output logic                  gnt_vld_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  always_comb begin
    // Rotate so that bit 0 of rot is requester ptr_i.
    dbl       = {req_i, req_i} >> ptr_i;
    rot       = dbl[NREQ-1:0];
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    // Scan downward so the lowest rotated position wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = TRNG_IDX_W'((int'(ptr_i) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/trng_arbiter.sv
// Shares one serial TRNG bit source between NREQ requesters.
// Round-robin grant, WIDTH-bit MSB-first word assembly, one-cycle response
// pulse, then a GAP_CYCLES idle gap for the entropy source to settle.
//
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   req           : per-requester word request (level, held until served)
//   rsp_valid     : one-hot response pulse
//   rsp_data      : response word, zero-extended, 0 when no pulse
//   busy          : high whenever the controller is not IDLE
//   trng_req      : entropy source enable, high while collecting
//   trng_bit      : serial random bit
//   health_clr    : clears the health alarm
//   health_fail   : sticky health alarm
//
// Optional feature macro: TRNG_HEALTH_EN enables a repetition-count test on
// the sampled bits. Without it health_fail is 0 and health_clr is ignored.
module trng_arbiter
  import trng_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int RCT_LIMIT  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [TRNG_RDATA_W-1:0] rsp_data,
  output logic                    busy,
  output logic                    trng_req,
  input  logic                    trng_bit,
  input  logic                    health_clr,
  output logic                    health_fail
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = 4;

  trng_state_e             state_q;
  logic [TRNG_IDX_W-1:0]   rr_ptr_q, grant_q, arb_idx;
  logic                    arb_vld;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH-1:0]        shift_q, word_d;
  logic [GAP_W-1:0]        gap_q;
  logic [NREQ-1:0]         rsp_valid_q, gnt_oh;
  logic [TRNG_RDATA_W-1:0] rsp_data_q;
  logic                    busy_q, trng_req_q;
  logic                    last_bit, arb_pt, go_collect, new_grant, deliver_ok;
  logic                    hold, retry, word_bad;

  trng_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  // Truncating the concatenation keeps the WIDTH-1 older bits plus the new one.
  assign word_d   = WIDTH'({shift_q, trng_bit});
  assign gnt_oh   = NREQ'(1) << grant_q;
  assign last_bit = (state_q == COLLECT) && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    // The IDLE decision is also taken in the final gap cycle (or in DELIVER
    // when there is no gap) so a pending request starts collecting without
    // an extra idle cycle between words.
    arb_pt = (state_q == IDLE) ||
             ((state_q == GAP) && (int'(gap_q) + 1 >= GAP_CYCLES)) ||
             ((state_q == DELIVER) && (GAP_CYCLES == 0));
    go_collect = arb_pt && !hold && (retry || arb_vld);
    new_grant  = go_collect && !retry;
    deliver_ok = (|(req & gnt_oh)) && !word_bad;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      gap_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      trng_req_q  <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      case (state_q)
        IDLE: ;
        COLLECT: begin
          shift_q <= word_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_q    <= DELIVER;
            trng_req_q <= 1'b0;
            if (deliver_ok) begin
              rsp_valid_q <= gnt_oh;
              rsp_data_q  <= TRNG_RDATA_W'(word_d);
            end
          end
        end
        DELIVER: begin
          shift_q <= '0;
          cnt_q   <= '0;
          gap_q   <= '0;
          state_q <= GAP;
        end
        GAP: gap_q <= gap_q + GAP_W'(1);
        default: state_q <= IDLE;
      endcase
      if (arb_pt) begin
        if (go_collect) begin
          state_q    <= COLLECT;
          busy_q     <= 1'b1;
          trng_req_q <= 1'b1;
        end else begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          trng_req_q <= 1'b0;
        end
        if (new_grant) begin
          grant_q  <= arb_idx;
          rr_ptr_q <= rr_next(arb_idx, NREQ);
        end
      end
    end
  end

`ifdef TRNG_HEALTH_EN
  logic [7:0] run_q, run_d;
  logic       last_q, hf_q, hf_d, retry_q, rct_hit;

  always_comb begin
    run_d   = run_q;
    rct_hit = 1'b0;
    if (state_q == COLLECT) begin
      if ((run_q == 8'd0) || (trng_bit != last_q)) run_d = 8'd1;
      else if (run_q < 8'(RCT_LIMIT))              run_d = run_q + 8'd1;
      rct_hit = (run_d == 8'(RCT_LIMIT));
    end
    // Clear wins over a same-cycle set.
    if (health_clr) begin
      run_d   = '0;
      rct_hit = 1'b0;
    end
    hf_d = !health_clr && (hf_q || rct_hit);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q   <= '0;
      last_q  <= 1'b0;
      hf_q    <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      run_q <= run_d;
      hf_q  <= hf_d;
      if (state_q == COLLECT) last_q <= trng_bit;
      // A word spoiled by the health alarm is retried for the same requester.
      if (last_bit && hf_d) retry_q <= 1'b1;
      else if (go_collect)  retry_q <= 1'b0;
    end
  end

  assign hold        = hf_q;
  assign retry       = retry_q;
  assign word_bad    = hf_d;
  assign health_fail = hf_q;
`else
  logic unused_health;
  assign unused_health = health_clr ^ (RCT_LIMIT > 0);
  assign hold          = 1'b0;
  assign retry         = 1'b0;
  assign word_bad      = 1'b0;
  assign health_fail   = 1'b0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign trng_req  = trng_req_q;

endmodule

// File: tb/tb_trng_arbiter.sv
`timescale 1ns/1ps
module tb_trng_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req = '0, req2 = '0;
  logic        trng_bit = 1'b0, health_clr = 1'b0;
  logic [2:0]  rsp_valid, rsp_valid2;
  logic [31:0] rsp_data, rsp_data2;
  logic        busy, busy2, trng_req, trng_req2, health_fail, health_fail2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int bmode = 0;   // 0: bench drives bits, 1: toggle by cycle parity, 2: stuck at 1

  always #5 clk = ~clk;

  trng_arbiter #(.NREQ(3), .WIDTH(8), .GAP_CYCLES(2), .RCT_LIMIT(16)) dut (
    .clk(clk), .resetn(resetn), .req(req), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .trng_req(trng_req), .trng_bit(trng_bit), .health_clr(health_clr),
    .health_fail(health_fail));

  trng_arbiter #(.NREQ(3), .WIDTH(8), .GAP_CYCLES(0), .RCT_LIMIT(16)) dut_g0 (
    .clk(clk), .resetn(resetn), .req(req2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .busy(busy2), .trng_req(trng_req2), .trng_bit(trng_bit), .health_clr(health_clr),
    .health_fail(health_fail2));

  typedef struct {
    logic [2:0]  rq;
    logic [7:0]  bits;
    logic [2:0]  vld;
    logic [31:0] data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bmode == 1)      trng_bit = cyc[0];
    else if (bmode == 2) trng_bit = 1'b1;
  endtask

  // Word collected with toggling bits starting at cycle s.
  function automatic logic [31:0] alt_word(input int s);
    return (s % 2 == 1) ? 32'hAA : 32'h55;
  endfunction

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < lim) begin
      tick();
      k++;
    end
    chk("wait idle busy", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      n_cmp++;
      if ($countones(rsp_valid) > 1 || (|rsp_valid && trng_req) ||
          $countones(rsp_valid2) > 1 || (|rsp_valid2 && trng_req2)) begin
        n_bad++;
        $display("FAIL invariant: rsp_valid=%b trng_req=%b rsp_valid2=%b trng_req2=%b",
                 rsp_valid, trng_req, rsp_valid2, trng_req2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[6];
    logic [2:0]  ev;
    logic        etr;

    vt[0] = '{3'b001, 8'hB2, 3'b001, 32'h0000_00B2};
    vt[1] = '{3'b100, 8'h5A, 3'b100, 32'h0000_005A};
    vt[2] = '{3'b011, 8'hFF, 3'b001, 32'h0000_00FF};
    vt[3] = '{3'b101, 8'h00, 3'b100, 32'h0000_0000};
    vt[4] = '{3'b110, 8'h81, 3'b010, 32'h0000_0081};
    vt[5] = '{3'b011, 8'h3C, 3'b001, 32'h0000_003C};

    // Reset state
    tick();
    tick();
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset trng_req", 32'(trng_req), 32'd0);
    chk("reset health_fail", 32'(health_fail), 32'd0);
    chk("reset g0 busy", 32'(busy2), 32'd0);
    chk("reset g0 trng_req", 32'(trng_req2), 32'd0);
    #3 resetn = 1'b1;
    tick();

    // Table: single words, round-robin pointer carried between vectors
    bmode = 0;
    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < 12; c++) begin
        chk($sformatf("v%0d c%0d trng_req", v, c), 32'(trng_req), 32'(c >= 1 && c <= 8));
        chk($sformatf("v%0d c%0d busy", v, c), 32'(busy), 32'(c >= 1 && c <= 11));
        chk($sformatf("v%0d c%0d rsp_valid", v, c), 32'(rsp_valid),
            32'((c == 9) ? vt[v].vld : 3'b000));
        chk($sformatf("v%0d c%0d rsp_data", v, c), rsp_data, (c == 9) ? vt[v].data : 32'd0);
        if (c == 0) req = vt[v].rq;
        if (c == 9) req = '0;
        trng_bit = (c >= 1 && c <= 8) ? vt[v].bits[8 - c] : 1'b0;
        tick();
      end
    end

    // Contention: all held, rr_ptr is 1 here so order is 1,2,0 at 11-cycle spacing
    bmode = 1;
    for (int c = 0; c <= 31; c++) begin
      etr = (c >= 1) && (((c - 1) % 11) < 8);
      ev  = (c == 9) ? 3'b010 : (c == 20) ? 3'b100 : (c == 31) ? 3'b001 : 3'b000;
      chk($sformatf("cont c%0d trng_req", c), 32'(trng_req), 32'(etr));
      chk($sformatf("cont c%0d rsp_valid", c), 32'(rsp_valid), 32'(ev));
      if (ev != 3'b000) chk($sformatf("cont c%0d rsp_data", c), rsp_data, alt_word(cyc - 8));
      if (c == 0)  req = 3'b111;
      if (c == 31) req = '0;
      tick();
    end
    wait_idle(20);

    // Requester drop: req[1] granted then dropped on 4th COLLECT cycle
    for (int c = 0; c <= 20; c++) begin
      etr = (c >= 1 && c <= 8) || (c >= 12 && c <= 19);
      chk($sformatf("drop c%0d trng_req", c), 32'(trng_req), 32'(etr));
      chk($sformatf("drop c%0d busy", c), 32'(busy), 32'(c >= 1));
      chk($sformatf("drop c%0d rsp_valid", c), 32'(rsp_valid),
          32'((c == 20) ? 3'b100 : 3'b000));
      if (c == 20) chk("drop rsp_data", rsp_data, alt_word(cyc - 8));
      if (c == 0)  req = 3'b110;
      if (c == 4)  req = 3'b100;
      if (c == 20) req = '0;
      tick();
    end
    wait_idle(20);

    // Async reset mid-COLLECT; rr_ptr moves to 2 before it
    for (int c = 0; c <= 5; c++) begin
      chk($sformatf("arst c%0d trng_req", c), 32'(trng_req), 32'(c >= 1));
      if (c == 0) req = 3'b010;
      if (c < 5) tick();
    end
    #2 resetn = 1'b0;
    #1;
    chk("arst trng_req immediate", 32'(trng_req), 32'd0);
    chk("arst busy immediate", 32'(busy), 32'd0);
    chk("arst rsp_valid immediate", 32'(rsp_valid), 32'd0);
    req = '0;
    tick();
    #3 resetn = 1'b1;
    tick();
    for (int c = 0; c <= 9; c++) begin
      chk($sformatf("post-reset c%0d rsp_valid", c), 32'(rsp_valid),
          32'((c == 9) ? 3'b001 : 3'b000));
      if (c == 0) req = 3'b111;
      if (c == 9) req = '0;
      tick();
    end
    wait_idle(20);

    // GAP_CYCLES=0 instance: words every 9 cycles, one low cycle of trng_req
    for (int c = 0; c <= 27; c++) begin
      chk($sformatf("g0 c%0d trng_req", c), 32'(trng_req2), 32'(c >= 1 && (c % 9) != 0));
      chk($sformatf("g0 c%0d busy", c), 32'(busy2), 32'(c >= 1));
      chk($sformatf("g0 c%0d rsp_valid", c), 32'(rsp_valid2),
          32'((c == 9 || c == 18 || c == 27) ? 3'b010 : 3'b000));
      if (c == 9 || c == 18 || c == 27)
        chk($sformatf("g0 c%0d rsp_data", c), rsp_data2, alt_word(cyc - 8));
      if (c == 0)  req2 = 3'b010;
      if (c == 27) req2 = '0;
      tick();
    end
    chk("g0 idle busy", 32'(busy2), 32'd0);

`ifdef TRNG_HEALTH_EN
    // Stuck-at-1 source: first word is 8 ones, alarm on the 16th sample
    #2 resetn = 1'b0;
    tick();
    #2 resetn = 1'b1;
    bmode = 2;
    tick();
    for (int c = 0; c <= 36; c++) begin
      etr = (c >= 1 && c <= 8) || (c >= 12 && c <= 19) || (c >= 28 && c <= 35);
      chk($sformatf("hlth c%0d health_fail", c), 32'(health_fail), 32'(c >= 20 && c <= 26));
      chk($sformatf("hlth c%0d busy", c), 32'(busy),
          32'((c >= 1 && c <= 22) || c >= 28));
      chk($sformatf("hlth c%0d trng_req", c), 32'(trng_req), 32'(etr));
      chk($sformatf("hlth c%0d rsp_valid", c), 32'(rsp_valid),
          32'((c == 9 || c == 36) ? 3'b001 : 3'b000));
      if (c == 9)  chk("hlth first rsp_data", rsp_data, 32'h0000_00FF);
      if (c == 36) chk("hlth retry rsp_data", rsp_data, alt_word(cyc - 8));
      if (c == 0)  req = 3'b001;
      if (c == 26) begin
        health_clr = 1'b1;
        bmode      = 1;
      end
      if (c == 27) health_clr = 1'b0;
      if (c == 36) req = '0;
      tick();
    end
    wait_idle(20);
`else
    health_clr = 1'b1;
    tick();
    chk("no-feature health_fail during clr", 32'(health_fail), 32'd0);
    health_clr = 1'b0;
    tick();
    chk("no-feature health_fail", 32'(health_fail), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trng_arbiter.md
Name: trng_arbiter

Overview:
- Sequences and shares the single serial TRNG bit source (trng_bit / trng_req) between NREQ on-chip requesters, e.g. the CPU-side TRNG MMIO port and the password-hash salt generator.
- Round-robin grant; assembles a WIDTH-bit word MSB-first, then returns it to the granted requester with a one-cycle response pulse.
- Inserts a programmable idle gap between words so the entropy source can settle.

Parameters:
- NREQ, 3: number of requesters (2..8).
- WIDTH, 8: bits per random word (1..32).
- GAP_CYCLES, 2: cycles with trng_req low after each word (0..15).
- RCT_LIMIT, 16: repetition-count cutoff; used only with the optional feature (2..255).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester word request; held high until the matching rsp_valid bit pulses.
- rsp_valid  out  NREQ  one-cycle pulse, one-hot; bit i means rsp_data is for requester i.
- rsp_data  out  32  random word, zero-extended from WIDTH; valid only while rsp_valid is nonzero, otherwise 0.
- busy  out  1  high in every state except IDLE.
- trng_req  out  1  enable/request to the entropy source.
- trng_bit  in  1  serial random bit, valid on every cycle trng_req is high.
- health_clr  in  1  clears health_fail.
- health_fail  out  1  sticky health alarm; tied 0 without the feature.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, bit counter=0, shift register=0. All outputs are 0.
- States: IDLE, COLLECT, DELIVER, GAP.
- IDLE:
  - If req is nonzero, grant the first requester with req high, searching upward from rr_ptr with wrap-around.
  - Latch the grant index, set rr_ptr to grant index + 1 (mod NREQ), go to COLLECT.
  - trng_req is 0.
- COLLECT:
  - trng_req is 1.
  - Each cycle: shift = {shift[WIDTH-2:0], trng_bit} and the counter increments.
  - After exactly WIDTH cycles, go to DELIVER.
  - The first sampled bit ends up as the word's MSB.
- DELIVER (1 cycle):
  - trng_req is 0.
  - If req[grant] is still high: rsp_valid[grant]=1 and rsp_data=shift.
  - If req[grant] dropped during COLLECT: the word is discarded and no pulse is issued.
  - Shift register and counter are cleared.
  - Go to GAP, or to IDLE if GAP_CYCLES is 0.
- GAP: trng_req is 0 for GAP_CYCLES cycles, then IDLE.
- Latency: req rises at cycle t (block in IDLE) → COLLECT from t+1 → rsp_valid at t+1+WIDTH.
- Requester conditions:
  - A requester may keep req high for back-to-back words. It is re-eligible from the next IDLE, behind the other requesters in round-robin order.
  - Requests arriving outside IDLE wait; nothing is queued beyond the req level.
  - Simultaneous requests are resolved by rr_ptr only. No requester is starved: worst-case wait is NREQ word slots.
- Invariants: rsp_valid is never more than one-hot; rsp_valid and trng_req are never high in the same cycle.
- Counter width is $clog2(WIDTH+1); the count never exceeds WIDTH.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- With the macro defined:
  - A repetition-count test runs over every sampled trng_bit.
  - The run counter restarts at 1 when the bit changes and saturates at RCT_LIMIT.
  - When the run reaches RCT_LIMIT, health_fail sets (sticky). The current word is discarded in DELIVER with no pulse, and the grant is kept: flow goes GAP → COLLECT for the same requester.
  - While health_fail=1, the block stays in IDLE and ignores req.
  - health_clr=1 clears health_fail and the run counter; clear has priority over a same-cycle set.
- Without the macro: no run counter logic, health_fail is constant 0, health_clr is ignored.

Decomposition:
- Shared package trng_pkg:
  - state enum (IDLE, COLLECT, DELIVER, GAP)
  - constant TRNG_RDATA_W=32
  - function for round-robin next-index.
- One sub-module: trng_rr_arb (combinational NREQ-way round-robin pick from req and rr_ptr, outputs the grant index and a valid flag).
- The controller, shifter and health test stay in the top module.

Test Plan:
- Single request: req=3'b001, trng_bit pattern 1,0,1,1,0,0,1,0 → rsp_valid=3'b001 exactly 9 cycles after req rises, rsp_data=32'h000000B2, trng_req high for exactly 8 cycles.
- Contention: req=3'b111 held continuously → grant order 0,1,2,0,…; consecutive words separated by 8+1+2=11 cycles; no two rsp_valid bits ever set together.
- Requester drop: req[1] deasserted on the 4th COLLECT cycle → no rsp_valid pulse; block returns to IDLE after 2 GAP cycles and serves req[2].
- Async reset mid-COLLECT: resetn low on the 5th COLLECT cycle → trng_req, busy and rsp_valid go 0 immediately without waiting for a clock edge; after release, the next grant goes to index 0.
- Gap parameter: GAP_CYCLES=0 with req=3'b010 held → words every 9 cycles, trng_req low for exactly 1 cycle between words.
- Health (TRNG_HEALTH_EN, RCT_LIMIT=16): trng_bit stuck at 1 → health_fail rises on the 16th sampled bit, no rsp_valid, block then idle. Pulse health_clr, switch to alternating bits → normal word delivered.
